dig_bcd_converter: RTL and testbench

// Upstream stage of the 7-segment display path. Captures the value the CPU writes to the
// DIG address (digcs && digwrite from memorio) and converts the binary to packed BCD

---
 rtl/dig_bcd_converter.sv | 85 ++++++++
 tb/tb_dig_bcd_converter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/dig_bcd_converter.sv
// dig_bcd_converter: captures DIG writes and converts them to packed BCD by shift-and-add-3,
// one bit per clock, with leading-zero mask and a one-deep pending slot for writes while busy.
module dig_bcd_converter #(
    parameter int BIN_W  = 17,
    parameter int DIGITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  digcs,
    input  logic                  digwrite,
    input  logic [BIN_W-1:0]      write_data,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  bcd_valid
);
    localparam int CW = $clog2(BIN_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state, state_nxt;
    logic [BIN_W-1:0]    bin_sr, pend_val, start_val;
    logic [4*DIGITS-1:0] scratch, adj, shifted;
    logic [DIGITS-1:0]   en;
    logic [CW-1:0]       cnt;
    logic                pend_flag, req, start, last;

    assign busy = state == SHIFT;
    assign done = state == DONE;

    always_comb begin
        req       = digcs && digwrite;
        last      = cnt == CW'(1);
        start     = (state == IDLE && req) || (state == DONE && (req || pend_flag));
        start_val = (state == DONE && !req) ? pend_val : write_data;
        state_nxt = start ? SHIFT : state == SHIFT ? (last ? DONE : SHIFT) : IDLE;
        adj       = '0;
        for (int d = 0; d < DIGITS; d++)
            adj[4*d+:4] = scratch[4*d+:4] >= 4'd5 ? scratch[4*d+:4] + 4'd3 : scratch[4*d+:4];
        shifted = {adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
        // a nonzero digit makes itself and every lower digit significant
        en = '0;
        for (int d = 0; d < DIGITS; d++)
            if (|shifted[4*d+:4]) en = en | DIGITS'((1 << (d + 1)) - 1);
        en[0] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            bin_sr    <= '0;
            scratch   <= '0;
            cnt       <= '0;
            pend_val  <= '0;
            pend_flag <= 1'b0;
            bcd_out   <= '0;
            digit_en  <= '0;
            bcd_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                bin_sr  <= start_val;
                scratch <= '0;
                cnt     <= CW'(BIN_W);
            end else if (state == SHIFT) begin
                scratch <= shifted;
                bin_sr  <= bin_sr << 1;
                cnt     <= cnt - CW'(1);
                if (last) begin
                    bcd_out   <= shifted;
                    digit_en  <= en;
                    bcd_valid <= 1'b1;
                end
            end
            // a DONE-cycle request is consumed directly by start, so it supersedes the slot
            if (req && state == SHIFT) begin
                pend_val  <= write_data;
                pend_flag <= 1'b1;
            end else if (start) begin
                pend_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dig_bcd_converter.sv
// tb_dig_bcd_converter: table vectors, hand-written corner sequences and random values
// checked against an arithmetic decimal model.
module tb_dig_bcd_converter;
    logic        clk = 1'b0, rst = 1'b0, digcs = 1'b0, digwrite = 1'b0;
    logic [16:0] write_data = '0;
    logic        busy, done, bcd_valid;
    logic [31:0] bcd_out;
    logic [7:0]  digit_en;
    int passed = 0, total = 0;

    dig_bcd_converter dut (
        .clk(clk), .rst(rst), .digcs(digcs), .digwrite(digwrite), .write_data(write_data),
        .busy(busy), .done(done), .bcd_out(bcd_out), .digit_en(digit_en), .bcd_valid(bcd_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          value;
        logic [31:0] bcd;
        logic [7:0]  en;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r = '0;
        for (int i = 0; i < 8; i++) begin
            r[4*i+:4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_en(input int v);
        logic [7:0] e = 8'h01;
        int p = 1;
        for (int i = 0; i < 8; i++) begin
            e[i] = e[i] | (v >= p);
            p = p * 10;
        end
        return e;
    endfunction

    // called at a negedge; request is sampled at the following posedge
    task automatic pulse(input logic cs, input logic wr, input int v);
        digcs = cs; digwrite = wr; write_data = 17'(v);
        @(negedge clk);
        digcs = 1'b0; digwrite = 1'b0;
    endtask

    task automatic wait_done(output int cyc, output int busy_cnt);
        cyc = 1; busy_cnt = 0;
        while (!done && cyc < 40) begin
            busy_cnt += int'(busy);
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            total++;
            $display("FAIL timeout: no done within %0d cycles", cyc);
        end
    endtask

    task automatic convert(input int v, input logic [31:0] eb, input logic [7:0] ee);
        int cyc, bc;
        pulse(1'b1, 1'b1, v);
        wait_done(cyc, bc);
        check($sformatf("latency(%0d)", v), 32'(cyc), 32'd18);
        check($sformatf("busy_cycles(%0d)", v), 32'(bc), 32'd17);
        check($sformatf("bcd(%0d)", v), bcd_out, eb);
        check($sformatf("digit_en(%0d)", v), 32'(digit_en), 32'(ee));
        check($sformatf("bcd_valid(%0d)", v), 32'(bcd_valid), 32'd1);
        @(negedge clk);
        check($sformatf("done_one_cycle(%0d)", v), 32'(done), 32'd0);
    endtask

    initial begin
        vec_t vecs[6];
        int cyc, bc, cnt_done, v;
        logic [31:0] prev;
        vecs[0] = '{0,      32'h00000000, 8'h01};
        vecs[1] = '{12345,  32'h00012345, 8'h1F};
        vecs[2] = '{131071, 32'h00131071, 8'h3F};
        vecs[3] = '{7,      32'h00000007, 8'h01};
        vecs[4] = '{99999,  32'h00099999, 8'h1F};
        vecs[5] = '{10,     32'h00000010, 8'h03};
        repeat (2) @(negedge clk);
        check("reset_bcd", bcd_out, 32'h0);
        check("reset_en", 32'(digit_en), 32'h0);
        check("reset_valid", 32'(bcd_valid), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        foreach (vecs[i]) convert(vecs[i].value, vecs[i].bcd, vecs[i].en);

        // newest pending wins; the next conversion follows DONE without an IDLE gap
        pulse(1'b1, 1'b1, 100);
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b1, 200);
        repeat (3) @(negedge clk);
        pulse(1'b1, 1'b1, 305);
        wait_done(cyc, bc);
        check("pend_first_bcd", bcd_out, 32'h100);
        @(negedge clk);
        check("pend_no_gap_busy", 32'(busy), 32'd1);
        check("pend_hold_bcd", bcd_out, 32'h100);
        wait_done(cyc, bc);
        check("pend_latency", 32'(cyc), 32'd18);
        check("pend_second_bcd", bcd_out, 32'h305);
        @(negedge clk);
        check("pend_200_lost", 32'(busy), 32'd0);

        // reset mid-conversion
        pulse(1'b1, 1'b1, 999);
        repeat (7) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_bcd", bcd_out, 32'h0);
        check("abort_en", 32'(digit_en), 32'h0);
        check("abort_valid", 32'(bcd_valid), 32'h0);
        check("abort_busy", 32'(busy), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        cnt_done = 0;
        repeat (25) begin
            @(negedge clk);
            cnt_done += int'(done);
        end
        check("abort_no_done", 32'(cnt_done), 32'd0);
        convert(7, 32'h7, 8'h01);

        // incomplete strobes are ignored
        prev = bcd_out;
        pulse(1'b0, 1'b1, 55);
        check("nocs_busy", 32'(busy), 32'd0);
        pulse(1'b1, 1'b0, 55);
        check("nowr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("ignored_bcd", bcd_out, prev);

        // write landing in the DONE cycle restarts immediately
        pulse(1'b1, 1'b1, 4321);
        wait_done(cyc, bc);
        check("b2b_first", bcd_out, 32'h4321);
        pulse(1'b1, 1'b1, 8765);
        check("b2b_busy", 32'(busy), 32'd1);
        wait_done(cyc, bc);
        check("b2b_latency", 32'(cyc), 32'd18);
        check("b2b_second", bcd_out, 32'h8765);
        @(negedge clk);

        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 131071));
            convert(v, ref_bcd(v), ref_en(v));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
